// File: rtl/usrt_link_ctrl.sv
// Round-robin scheduler sharing one USRT link among NREQ byte requesters:
// load/SEND/wait-for-NINTO sequencing with timeout, plus an independent RX capture path.
`timescale 1ns/1ps
module usrt_link_ctrl #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic              err,
  output logic              load,
  output logic [7:0]        Tx_Data,
  output logic              SEND,
  input  logic              NINTO,
  input  logic              NINTI,
  output logic              READ,
  input  logic [7:0]        Rx_Data,
  output logic              rx_valid,
  output logic [7:0]        rx_byte
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_FIRE = CNTW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            load_q, load_d;
  logic            send_q, send_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            ninto_prev_q, ninto_prev_d;
  logic            ninti_prev_q, ninti_prev_d;
  logic            ninto_fall, ninti_fall;

  logic            read_q, read_d;
  logic            cap_q, cap_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_byte_q, rx_byte_d;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] cand_idx;

  // Both edge registers run every cycle; only WAIT consumes the NINTO edge.
  always_comb begin
    ninto_prev_d = NINTO;
    ninti_prev_d = NINTI;
    ninto_fall   = ninto_prev_q & ~NINTO;
    ninti_fall   = ninti_prev_q & ~NINTI;
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_idx = IDXW'((int'(rr_q) + k) % NREQ);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    load_d    = 1'b0;
    send_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d         = S_LOAD;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          rr_d            = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDXW'(1);
          tx_data_d       = req_data[8*int'(pick_idx) +: 8];
          load_d          = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        send_d  = 1'b1;
      end
      S_SEND: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNTW'(1);
        // A frame-done edge in the final counted cycle still beats the timeout.
        if (ninto_fall || cnt_q == CNT_FIRE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = ~ninto_fall;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh NINTI edge cancels any capture still in flight.
  always_comb begin
    read_d     = ninti_fall;
    cap_d      = read_q & ~ninti_fall;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    if (cap_q && !ninti_fall) begin
      rx_byte_d  = Rx_Data;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      tx_data_q    <= 8'h00;
      cnt_q        <= '0;
      load_q       <= 1'b0;
      send_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ninto_prev_q <= 1'b1;
      ninti_prev_q <= 1'b1;
      read_q       <= 1'b0;
      cap_q        <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      tx_data_q    <= tx_data_d;
      cnt_q        <= cnt_d;
      load_q       <= load_d;
      send_q       <= send_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ninto_prev_q <= ninto_prev_d;
      ninti_prev_q <= ninti_prev_d;
      read_q       <= read_d;
      cap_q        <= cap_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign load     = load_q;
  assign Tx_Data  = tx_data_q;
  assign SEND     = send_q;
  assign READ     = read_q;
  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;

endmodule
